// File: rtl/div_const_reconstruct.sv
// Digit-serial reconstruction of a dividend from a constant-divisor quotient/remainder pair:
// x_out = DIVISOR*q_in + r_in, with err_out raised when the remainder is out of range.
module div_const_reconstruct #(
    parameter int WIDTH   = 16,
    parameter int DIVISOR = 5,
    parameter int DIGIT   = 4,
    localparam int RW     = $clog2(DIVISOR),
    localparam int OW     = WIDTH + RW,
    localparam int NDIG   = WIDTH / DIGIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] q_in,
    input  logic [RW-1:0]   r_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   x_out,
    output logic            err_out
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    // One digit product plus carry: DIVISOR*(2^DIGIT-1) + carry fits in DIGIT+RW+1 bits.
    localparam int TW = DIGIT + RW + 1;
    localparam logic [RW:0]   DIV_C    = (RW + 1)'(DIVISOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] x_sh;
    logic [RW:0]      carry;
    logic [CW-1:0]    cnt;
    logic             err_r;

    logic [TW-1:0]    t_p0;
    logic [WIDTH-1:0] x_next_p0;
    logic [RW:0]      carry_next_p0;

    function automatic logic [TW-1:0] digit_step(input logic [DIGIT-1:0] d,
                                                 input logic [RW:0]      c);
        digit_step = TW'(DIVISOR) * TW'(d) + TW'(c);
    endfunction

    function automatic logic rem_illegal(input logic [RW-1:0] r);
        rem_illegal = ({1'b0, r} >= DIV_C);
    endfunction

    // Digit datapath: one multiply-accumulate per cycle, low digit shifted into X from the top.
    always_comb begin
        t_p0          = digit_step(q_sh[DIGIT-1:0], carry);
        x_next_p0     = {t_p0[DIGIT-1:0], x_sh[WIDTH-1:DIGIT]};
        carry_next_p0 = t_p0[TW-1:DIGIT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            err_out   <= 1'b0;
            q_sh      <= '0;
            x_sh      <= '0;
            carry     <= '0;
            cnt       <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q_sh     <= q_in;
                        carry    <= {1'b0, r_in};
                        err_r    <= rem_illegal(r_in);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    q_sh  <= q_sh >> DIGIT;
                    x_sh  <= x_next_p0;
                    carry <= carry_next_p0;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Final carry is bounded by DIVISOR, so its top bit is always zero here.
                        x_out     <= {carry_next_p0[RW-1:0], x_next_p0};
                        err_out   <= err_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_const_reconstruct.sv
// Bench for div_const_reconstruct: table vectors, random vectors and handshake corner cases,
// with expected results queued at acceptance and compared when the result is handed off.
module tb_div_const_reconstruct;

    localparam int WIDTH   = 16;
    localparam int DIVISOR = 5;
    localparam int DIGIT   = 4;
    localparam int RW      = 3;
    localparam int OW      = 19;
    localparam int NDIG    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] q_in;
    logic [RW-1:0]   r_in;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   x_out;
    logic            err_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int q;
        int r;
        int x;
        int e;
    } vec_t;

    typedef struct {
        int x;
        int e;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_const_reconstruct #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .DIGIT(DIGIT)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .q_in(q_in),
        .r_in(r_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out(x_out),
        .err_out(err_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for its result with out_ready high, check latency and handoff.
    task automatic run_one(input int q, input int r, input int xexp, input int eexp);
        int   waited;
        int   lat;
        exp_t e;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        q_in     = WIDTH'(q);
        r_in     = RW'(r);
        sb.push_back('{x: xexp, e: eexp});
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(NDIG));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("x_out", 32'(x_out), 32'(e.x));
            chk("err_out", 32'(err_out), 32'(e.e));
        end
        tick();
        chk("out_valid_after_handoff", 32'(out_valid), 32'd0);
        chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        int   q;
        int   r;
        int   waited;
        logic [OW-1:0] held_x;
        logic          held_e;
        exp_t          e;

        tbl[0] = '{q: 13107, r: 0, x: 65535,  e: 0};
        tbl[1] = '{q: 65535, r: 4, x: 327679, e: 0};
        tbl[2] = '{q: 0,     r: 0, x: 0,      e: 0};
        tbl[3] = '{q: 1,     r: 3, x: 8,      e: 0};
        tbl[4] = '{q: 100,   r: 6, x: 506,    e: 1};
        tbl[5] = '{q: 65535, r: 7, x: 327682, e: 1};
        tbl[6] = '{q: 12345, r: 2, x: 61727,  e: 0};
        tbl[7] = '{q: 32768, r: 5, x: 163845, e: 1};
        tbl[8] = '{q: 1,     r: 0, x: 5,      e: 0};
        tbl[9] = '{q: 43690, r: 1, x: 218451, e: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q_in      = '0;
        r_in      = '0;
        repeat (3) tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_x_out", 32'(x_out), 32'd0);
        chk("reset_err_out", 32'(err_out), 32'd0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) run_one(tbl[i].q, tbl[i].r, tbl[i].x, tbl[i].e);

        for (int k = 0; k < 300; k++) begin
            q = int'($urandom_range(65535));
            r = int'($urandom_range(DIVISOR - 1));
            run_one(q, r, DIVISOR * q + r, 0);
            chk("quotient_back", 32'(int'(x_out) / DIVISOR), 32'(q));
        end

        // Backpressure: result held for 10 cycles while new requests are offered and ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        q_in      = 16'd1234;
        r_in      = 3'd2;
        sb.push_back('{x: 6172, e: 0});
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("bp_latency", 32'(waited), 32'(NDIG));
        held_x = x_out;
        held_e = err_out;
        e = sb.pop_front();
        chk("bp_x_out", 32'(x_out), 32'(e.x));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            q_in     = 16'(k * 777);
            r_in     = 3'(k);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_x_held", 32'(x_out), 32'(held_x));
            chk("bp_err_held", 32'(err_out), 32'(held_e));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        repeat (6) tick();
        chk("bp_no_ghost_result", 32'(out_valid), 32'd0);

        // Reset in the middle of a computation abandons it.
        in_valid = 1'b1;
        q_in     = 16'd9999;
        r_in     = 3'd1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_x_out", 32'(x_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) tick();
        chk("midrst_no_result", 32'(out_valid), 32'd0);
        run_one(7, 2, 37, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
